// File: rtl/oh_clockdiv_bank.sv
`default_nettype none
// ==== oh_clockdiv_bank : N-channel programmable clock divider bank with shadowed config (rev 1.0) ====
module oh_clockdiv_bank #(
   parameter int N  = 4,
   parameter int DW = 8
) (
   input  logic            i_clk,
   input  logic            i_nreset,
   input  logic [N-1:0]    i_en,
   input  logic            i_sync,
   input  logic [N-1:0]    i_cfg_load,
   input  logic [N*DW-1:0] i_cfg_div,
   input  logic [N*DW-1:0] i_cfg_rise,
   input  logic [N*DW-1:0] i_cfg_fall,
   output logic [N-1:0]    o_clkout,
   output logic [N-1:0]    o_clkrise,
   output logic [N-1:0]    o_clkfall,
   output logic [N-1:0]    o_pending,
   output logic [N-1:0]    o_running
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;

   for (genvar gi = 0; gi < N; gi++) begin : g_ch
      logic [DW-1:0] r_div, r_rise, r_fall;
      logic [DW-1:0] r_sdiv, r_srise, r_sfall;
      logic [DW-1:0] r_cnt;
      logic [1:0]    r_state;
      logic          r_pend;
      logic          r_out;

      logic          w_active;
      logic          w_wrap;
      logic          w_apply;
      logic          w_start;
      logic [DW-1:0] w_div_eff;
      logic [DW-1:0] w_cnt_nxt;
      logic          w_out_nxt;

      assign w_active  = (r_state != S_IDLE);
      assign w_wrap    = w_active && (r_cnt == r_div);
      // Shadow only reaches the active set at a period boundary or while idle.
      assign w_apply   = r_pend && (!w_active || w_wrap);
      assign w_div_eff = w_apply ? r_sdiv : r_div;
      assign w_start   = i_en[gi] && (w_div_eff != '0);
      assign w_cnt_nxt = w_wrap ? '0 : r_cnt + 1'b1;
      // Fall has priority so rise==fall keeps the output low.
      assign w_out_nxt = (r_cnt == r_fall) ? 1'b0 :
                         (r_cnt == r_rise) ? 1'b1 : r_out;

      always_ff @(posedge i_clk or negedge i_nreset) begin
         if (!i_nreset) begin
            r_div   <= '0;
            r_rise  <= '0;
            r_fall  <= '0;
            r_sdiv  <= '0;
            r_srise <= '0;
            r_sfall <= '0;
            r_cnt   <= '0;
            r_state <= S_IDLE;
            r_pend  <= 1'b0;
            r_out   <= 1'b0;
         end else begin
            if (i_cfg_load[gi]) begin
               r_sdiv  <= i_cfg_div[gi*DW +: DW];
               r_srise <= i_cfg_rise[gi*DW +: DW];
               r_sfall <= i_cfg_fall[gi*DW +: DW];
               r_pend  <= 1'b1;
            end else if (w_apply) begin
               r_pend  <= 1'b0;
            end

            if (w_apply) begin
               r_div  <= r_sdiv;
               r_rise <= r_srise;
               r_fall <= r_sfall;
            end

            case (r_state)
               S_IDLE: begin
                  r_cnt <= '0;
                  r_out <= 1'b0;
                  if (w_start) r_state <= S_RUN;
               end
               S_RUN: begin
                  if (i_sync) begin
                     r_cnt <= '0;
                     r_out <= 1'b0;
                  end else begin
                     r_cnt <= w_cnt_nxt;
                     r_out <= w_out_nxt;
                  end
                  if (w_wrap && (w_div_eff == '0)) begin
                     r_state <= S_IDLE;
                     r_cnt   <= '0;
                     r_out   <= 1'b0;
                  end else if (!i_en[gi]) begin
                     r_state <= S_DRAIN;
                  end
               end
               S_DRAIN: begin
                  if (i_sync || (w_wrap && !w_start)) begin
                     r_state <= S_IDLE;
                     r_cnt   <= '0;
                     r_out   <= 1'b0;
                  end else begin
                     r_cnt <= w_cnt_nxt;
                     r_out <= w_out_nxt;
                     if (i_en[gi]) r_state <= S_RUN;
                  end
               end
               default: r_state <= S_IDLE;
            endcase
         end
      end

      assign o_clkout[gi]  = r_out;
      assign o_pending[gi] = r_pend;
      assign o_running[gi] = w_active;
      assign o_clkrise[gi] = w_active && (r_cnt == r_rise) && (r_rise != r_fall);
      assign o_clkfall[gi] = w_active && (r_cnt == r_fall);
   end

endmodule
`default_nettype wire

// File: doc/oh_clockdiv_bank.md
# oh_clockdiv_bank

Multi-channel programmable clock divider producing N independent divided clocks from one fast clock, each with a programmable period, rising-edge phase and falling-edge phase (duty cycle). It generalises the single-channel 4-bit divider to a bank: wider ratios, per-channel phase/duty, glitch-free shadowed reconfiguration, graceful stop and a global phase-align input. It sits in the clocking block feeding link/serdes logic, and also emits per-channel edge strobes for clock-enable style designs.

## Interface
- N, 4, number of channels
- DW, 8, counter/config width per channel; max period 2^DW cycles
- clk  in  1  fast source clock; all logic on rising edge
- nreset  in  1  asynchronous active-low reset
- en  in  N  per-channel run enable
- sync  in  1  single-cycle pulse; realigns all running channels to count 0
- cfg_load  in  N  per-channel pulse; captures cfg_* into that channel's shadow
- cfg_div  in  N*DW  period minus 1; channel i at [i*DW +: DW]
- cfg_rise  in  N*DW  count at which output is set
- cfg_fall  in  N*DW  count at which output is cleared
- clkout  out  N  divided clocks, registered
- clkrise  out  N  high in the cycle before clkout rises
- clkfall  out  N  high in the cycle before clkout falls
- pending  out  N  shadow loaded, not yet active
- running  out  N  channel in RUN or DRAIN

## Operation
- Per channel: active config (div, rise, fall), shadow config, counter cnt[DW-1:0], state IDLE/RUN/DRAIN, output flop.
- Counter: in RUN/DRAIN, cnt wraps to 0 when cnt==div, else cnt+1. Period = div+1 cycles.
- Output: next clkout = 1 when cnt==rise; 0 when cnt==fall; else hold. rise==fall: fall wins, output stays low. rise or fall > div: that edge never occurs, output holds.
- div==0 is "stopped": channel never leaves IDLE.
- clkrise = running & cnt==rise & rise!=fall; clkfall = running & cnt==fall; decoded from registered state only, no input paths.
- cfg_load: shadow ← cfg_* of that channel, pending←1. Shadow copied to active and pending←0 at the wrap (cnt==div) in RUN/DRAIN, or on the next edge in IDLE. Load on the same edge as apply: new value captured, pending stays 1, applied at next wrap.
- State IDLE: cnt=0, clkout=0. en & active div!=0 (after any pending apply) → RUN, cnt=0.
- RUN: en low → DRAIN. sync → cnt←0, clkout←0 (period may be truncated).
- DRAIN: counting continues; at wrap → IDLE, clkout←0. en high again before wrap → RUN without disturbance. sync → IDLE immediately.
- Channels fully independent except for shared sync.
- nreset asserted mid-operation: all state cleared immediately, regardless of clk.

## Timing
- Reset values: clkout=0, clkrise=0, clkfall=0, pending=0, running=0, cnt=0, state IDLE, active and shadow config all 0.
- en sampled at edge T (IDLE→RUN, cnt=0); with rise=0, clkrise high T..T+1, clkout high from edge T+1.
- clkout changes exactly one cycle after the cnt match; clkrise/clkfall lead clkout edges by one cycle.
- sync sampled at edge T: cnt=0 and clkout=0 after T; all synced channels share phase thereafter if equal div.
- cfg_load to effect: 1 cycle in IDLE; otherwise at end of the current period, never mid-period.

## Test plan
- Reset/basic: load div=3,rise=0,fall=2 on ch0, en=1 → clkout period 4, high 2/low 2, clkrise one cycle before each rise, running=1; all outputs 0 during reset.
- Duty/phase: div=4,rise=1,fall=2 → period 5, high 1 cycle; rise==fall=1 → clkout constant 0, clkrise never.
- Shadowed reconfig: running div=7, load div=2 mid-period → pending=1, current 8-cycle period completes intact, then period 3, pending=0.
- Graceful stop: drop en at cnt=1 of div=5 → running until wrap, then IDLE, clkout 0, no truncated high pulse; re-raise en before wrap → no gap.
- Sync align: ch0 div=3, ch1 div=3 out of phase, pulse sync → both cnt=0, identical clkout thereafter; sync in DRAIN → IDLE next edge.
- Async reset mid-run: assert nreset between clk edges with clkout high → clkout drops immediately, all channels IDLE, configs 0.
